// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control bus between the multi-cycle sequencer and the MIPS datapath
interface mc_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0] opcode, funct;
    logic zero, mem_ready;
    logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic reg_write, alu_src_a, ext_sel, illegal_instr;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state;
    logic [CNT_W-1:0] instr_count;
    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
        output reg_write, alu_src_a, ext_sel, illegal_instr,
        output reg_dst, mem_to_reg, alu_src_b, pc_source, alu_op, state, instr_count
    );
    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
        input  reg_write, alu_src_a, ext_sel, illegal_instr,
        input  reg_dst, mem_to_reg, alu_src_b, pc_source, alu_op, state, instr_count
    );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS sequencer driving datapath selects, strobes and ALU ops
module mc_control_fsm #(parameter int CNT_W = 32) (
    input logic clk,
    input logic rst,
    mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB,
                              BRANCH, JUMP, I_EXEC, I_WB, JR, JAL, TRAP, BAD} state_t;
    state_t st, nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0] r_op, i_op;
    logic r_ok, is_andi, retire;
    assign r_ok = bus.funct inside {6'h20, 6'h24, 6'h27, 6'h2a};
    assign r_op = bus.funct == 6'h24 ? 3'b000 : bus.funct == 6'h27 ? 3'b100 :
                  bus.funct == 6'h2a ? 3'b111 : 3'b010;
    assign is_andi = bus.opcode == 6'h0c;
    assign i_op = is_andi ? 3'b000 : 3'b010;
    // TRAP and the unreachable encoding never count as retirements
    assign retire = nxt == FETCH && st inside {MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, I_WB, JR, JAL};
    assign bus.state = st;
    assign bus.instr_count = cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= FETCH;
            cnt <= '0;
        end else begin
            st <= nxt;
            cnt <= cnt + CNT_W'(retire);
        end
    end
    always_comb begin
        nxt = FETCH;
        bus.pc_write = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord = 1'b0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.ir_write = 1'b0;
        bus.reg_write = 1'b0;
        bus.alu_src_a = 1'b0;
        bus.ext_sel = 1'b0;
        bus.illegal_instr = 1'b0;
        bus.reg_dst = 2'b00;
        bus.mem_to_reg = 2'b00;
        bus.alu_src_b = 2'b00;
        bus.pc_source = 2'b00;
        bus.alu_op = 3'b000;
        case (st)
            FETCH: begin
                bus.mem_read = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.alu_op = 3'b010;
                bus.ir_write = bus.mem_ready;
                bus.pc_write = bus.mem_ready;
                nxt = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alu_src_b = 2'b11;
                bus.alu_op = 3'b010;
                case (bus.opcode)
                    6'h00: nxt = r_ok ? R_EXEC : bus.funct == 6'h08 ? JR : TRAP;
                    6'h23, 6'h2b: nxt = MEM_ADDR;
                    6'h04: nxt = BRANCH;
                    6'h02: nxt = JUMP;
                    6'h03: nxt = JAL;
                    6'h08, 6'h0c: nxt = I_EXEC;
                    default: nxt = TRAP;
                endcase
            end
            MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op = 3'b010;
                nxt = bus.opcode == 6'h2b ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord = 1'b1;
                nxt = bus.mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                bus.reg_write = 1'b1;
                bus.mem_to_reg = 2'b01;
            end
            MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.iord = 1'b1;
                nxt = bus.mem_ready ? FETCH : MEM_WR;
            end
            R_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op = r_op;
                nxt = R_WB;
            end
            R_WB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst = 2'b01;
                bus.alu_op = r_op;
            end
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op = 3'b110;
                bus.pc_write_cond = 1'b1;
                bus.pc_source = 2'b01;
            end
            JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_source = 2'b10;
            end
            I_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_op = i_op;
                bus.ext_sel = is_andi;
                nxt = I_WB;
            end
            I_WB: begin
                bus.reg_write = 1'b1;
                bus.alu_op = i_op;
                bus.ext_sel = is_andi;
            end
            JR: begin
                bus.pc_write = 1'b1;
                bus.pc_source = 2'b11;
            end
            JAL: begin
                bus.reg_write = 1'b1;
                bus.reg_dst = 2'b10;
                bus.mem_to_reg = 2'b10;
                bus.pc_write = 1'b1;
                bus.pc_source = 2'b10;
            end
            TRAP: begin
                bus.illegal_instr = 1'b1;
                nxt = TRAP;
            end
            default: nxt = FETCH;
        endcase
    end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle sequencer for the MIPS datapath; replaces per-instruction single-cycle decode with a state machine that reuses one ALU and one unified memory port across Fetch/Decode/Execute/Memory/Writeback.
- Drives all datapath mux selects, write enables and ALU operation codes.
- Stalls on a memory ready handshake, traps illegal encodings and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- iord  out  1  memory address: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 B, 01 const 4, 10 extended imm, 11 imm<<2.
- ext_sel  out  1  0 = sign-extend, 1 = zero-extend.
- alu_op  out  3  000 AND, 001 OR, 010 ADD, 100 NOR, 110 SUB, 111 SLT.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A (jr).
- state  out  4  current state, for debug.
- illegal_instr  out  1  high in TRAP.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Moore FSM; outputs are a function of state only, except strobes gated by mem_ready (noted below). Every output not listed for a state is 0.
- rst asserted at any time, including mid-instruction or during a stall: state = FETCH (0), instr_count = 0. Output values during and after reset are therefore the FETCH outputs: mem_read = 1, alu_src_b = 01, alu_op = 010, all other outputs 0, pc_write = ir_write = mem_ready.
- FETCH (0): mem_read, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = ADD. ir_write and pc_write (pc_source = 00) are asserted only when mem_ready = 1. Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE (1): alu_src_a = 0, alu_src_b = 11, alu_op = ADD (precomputes branch target).
  - Next state by opcode: 000000 with funct 100000/100100/100111/101010 → R_EXEC; 000000 with funct 001000 → JR.
  - 100011/101011 → MEM_ADDR; 000100 → BRANCH; 000010 → JUMP; 000011 → JAL; 001000/001100 → I_EXEC.
  - Any other opcode/funct → TRAP.
- MEM_ADDR (2): alu_src_a = 1, alu_src_b = 10, ext_sel = 0, ADD. lw → MEM_RD; sw → MEM_WR.
- MEM_RD (3): mem_read, iord = 1. Hold until mem_ready, then → MEM_WB.
- MEM_WB (4): reg_write, reg_dst = 00, mem_to_reg = 01. → FETCH.
- MEM_WR (5): mem_write, iord = 1. Hold until mem_ready, then → FETCH. mem_write stays asserted throughout the stall.
- R_EXEC (6): alu_src_a = 1, alu_src_b = 00. alu_op from funct: add → 010, and → 000, nor → 100, slt → 111. → R_WB.
- R_WB (7): reg_write, reg_dst = 01, mem_to_reg = 00, alu_op held from R_EXEC. → FETCH.
- BRANCH (8): alu_src_a = 1, alu_src_b = 00, SUB, pc_write_cond, pc_source = 01. → FETCH.
- JUMP (9): pc_write, pc_source = 10. → FETCH.
- I_EXEC (10): alu_src_a = 1, alu_src_b = 10. addi: ADD with ext_sel = 0; andi: AND with ext_sel = 1. → I_WB.
- I_WB (11): reg_write, reg_dst = 00, mem_to_reg = 00, alu_op and ext_sel held. → FETCH.
- JR (12): pc_write, pc_source = 11. → FETCH.
- JAL (13): reg_write, reg_dst = 10, mem_to_reg = 10 (PC already holds PC+4), pc_write, pc_source = 10. → FETCH.
- TRAP (14): illegal_instr = 1, no writes; sticky until rst. Encoding 15 is unreachable and recovers to FETCH.
- instr_count increments by 1, wrapping modulo 2^CNT_W, on each transition into FETCH from states 4, 5 (on mem_ready), 7, 8, 9, 11, 12, 13. It does not increment on reset or on TRAP.
- Cycle counts with zero wait states:
  - lw 5; sw 4; R-type 4; addi/andi 4; beq 3; j/jr/jal 3.
  - Each mem_ready = 0 cycle adds one cycle in FETCH, MEM_RD or MEM_WR.

Test Plan:
- Reset mid-MEM_RD, then hold mem_ready = 1 → state = 0 at once with outputs at FETCH values; instr_count = 0.
- add (opcode 0, funct 0x20), mem_ready = 1 → states 0,1,6,7,0. In state 7: reg_write = 1, reg_dst = 01, alu_op = 010. instr_count = 1.
- lw with mem_ready low for 3 cycles in FETCH and 2 in MEM_RD → 10 cycles total; ir_write pulses exactly once; state 4 has mem_to_reg = 01.
- beq with zero = 1, then zero = 0 → pc_write_cond = 1 and pc_source = 01 in state 8 in both cases; 3 cycles each.
- jal (0x03) → state 13: reg_dst = 10, mem_to_reg = 10, pc_write = 1, pc_source = 10. andi → ext_sel = 1 and alu_op = 000 in states 10 and 11.
- opcode 0x3F → TRAP, illegal_instr = 1 held for 20 cycles with no write strobes; count unchanged. CNT_W = 4 with 17 retired instructions → instr_count = 1.
